// File: rtl/mac_mod_iter.sv
// Iterative multiply-add: result = (a*b + c) mod 2^OUT_W, consuming K multiplier bits per cycle.
// Handshake: start is taken only while ready_o=1; done_o pulses once with result_o/ovf_o, which hold until the next done_o.
module mac_mod_iter #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 9,
  parameter int WIDTH_C = 17,
  parameter int OUT_W   = 18,
  parameter int K       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH_A-1:0] a_i,
  input  logic [WIDTH_B-1:0] b_i,
  input  logic [WIDTH_C-1:0] c_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [OUT_W-1:0]   result_o,
  output logic               ovf_o,
  output logic               dbg_state_o
);

  localparam int AB_W  = WIDTH_A + WIDTH_B;
  localparam int ACC_W = ((AB_W > WIDTH_C) ? AB_W : WIDTH_C) + 1;
  localparam int N     = WIDTH_B / K;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH_B-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]   partial;
  logic [ACC_W-1:0]   acc_next;
  logic               ovf_next;
  logic               last_iter;

  // Multiplicand is pre-shifted and multiplier consumed from the LSB, so digit i lands at weight 2^(iK).
  assign partial   = mcand_q * ACC_W'(mplier_q[K-1:0]);
  assign acc_next  = acc_q + partial;
  assign last_iter = (cnt_q == CNT_W'(N - 1));

  generate
    if (OUT_W < ACC_W) begin : g_ovf
      assign ovf_next = |acc_next[ACC_W-1:OUT_W];
    end else begin : g_no_ovf
      assign ovf_next = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = BUSY;
          acc_d    = ACC_W'(c_i);
          mcand_d  = ACC_W'(a_i);
          mplier_d = b_i;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << K;
          mplier_d = mplier_q >> K;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_d  = IDLE;
            result_d = acc_next[OUT_W-1:0];
            ovf_d    = ovf_next;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q == BUSY);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule
